// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the canonical NOP encoding, the default reset PC and the fetch FSM states.
package fetch_unit_pkg;

    localparam int          PC_WIDTH_DEF   = 32;
    localparam int          INST_WIDTH_DEF = 32;
    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // BOOT lasts exactly one cycle after reset release, then RUN forever.
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, used both as the
// instruction buffer and as the PC tag queue. DEPTH must be a power of two.
// The head entry is visible combinationally on rdata.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    // Pointer and occupancy update; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

    // Upstream credit accounting must never push into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues word reads on the
// instruction-read bus, buffers responses with their PCs and hands them to
// the decoder. Redirects flush the buffer and drop stale in-flight responses.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect halts
// fetch and raises the sticky fetch_misaligned output).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
    parameter int                  INST_WIDTH = INST_WIDTH_DEF,
    parameter int                  FIFO_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [PC_WIDTH-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [INST_WIDTH-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  fetch_misaligned
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = INST_WIDTH + PC_WIDTH;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]       out_q, out_d;
    logic [CW-1:0]       drop_q, drop_d;

    logic                addr_hs, data_hs, keep_rsp, drop_active;
    logic                credit_ok, fetch_halt;
    logic [CW:0]         inflight;

    logic [BW-1:0]       ibuf_rdata;
    logic                ibuf_empty;
    logic [CW-1:0]       ibuf_count;
    logic [PC_WIDTH-1:0] tag_rdata;

    logic                unused_ibuf_full, unused_tag_full, unused_tag_empty;
    logic [CW-1:0]       unused_tag_count;

    assign addr_hs     = ir_addr_valid && ir_addr_ready;
    assign data_hs     = ir_data_valid && ir_data_ready;
    assign drop_active = (drop_q != '0);
    // A response in a redirect cycle is stale too, so it is never buffered.
    assign keep_rsp    = data_hs && !drop_active && !redirect_valid;

    // Requests in flight plus buffered entries may never exceed the buffer.
    assign inflight    = {1'b0, out_q} + {1'b0, ibuf_count};
    assign credit_ok   = (inflight < (CW + 1)'(FIFO_DEPTH));

    assign ir_addr       = pc_q;
    assign ir_data_ready = rst;
    assign inst_valid    = !ibuf_empty;
    assign inst          = ibuf_rdata[PC_WIDTH +: INST_WIDTH];
    assign inst_pc       = ibuf_rdata[PC_WIDTH-1:0];

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    // Sticky misalignment flag; once set, fetch stays halted until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end

    assign fetch_misaligned = misaligned_q;
    assign fetch_halt       = misaligned_q;
`else
    logic unused_rpc_low;
    assign unused_rpc_low = ^redirect_pc[1:0];
    assign fetch_halt     = 1'b0;
`endif

    // Next-state for FSM, PC and counters, plus the address-valid output.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_d         = out_q;
        drop_d        = drop_q;
        ir_addr_valid = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  begin
                state_d       = ST_RUN;
                ir_addr_valid = credit_ok && !fetch_halt;
            end
            default: state_d = ST_BOOT;
        endcase

        if (addr_hs) pc_d = pc_q + PC_WIDTH'(4);

        if (addr_hs && !data_hs)      out_d = out_q + 1'b1;
        else if (!addr_hs && data_hs) out_d = out_q - 1'b1;

        // Redirect target beats pc+4; everything still in flight afterwards
        // belongs to the old stream and must be dropped on return.
        if (redirect_valid) begin
            pc_d   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            drop_d = out_d;
        end else if (data_hs && drop_active) begin
            drop_d = drop_q - 1'b1;
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // Instruction buffer: {instruction, pc} toward the decoder.
    fetch_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (keep_rsp),
        .wdata ({ir_data, tag_rdata}),
        .pop   (inst_valid && inst_ready),
        .rdata (ibuf_rdata),
        .full  (unused_ibuf_full),
        .empty (ibuf_empty),
        .count (ibuf_count)
    );

    // PC tag queue: address of each live request, in issue order.
    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (addr_hs && !redirect_valid),
        .wdata (pc_q),
        .pop   (keep_rsp),
        .rdata (tag_rdata),
        .full  (unused_tag_full),
        .empty (unused_tag_empty),
        .count (unused_tag_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order bus model with configurable latency, a
// stream-level reference (expected decoder PC sequence and expected fetch
// address sequence), a per-cycle vector table for start-up timing, directed
// redirect/wrap sequences and a randomized phase.
module tb_fetch_unit;

    localparam int          PCW    = 32;
    localparam int          IW     = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ir_addr_valid, ir_addr_ready;
    logic [PCW-1:0]  ir_addr;
    logic            ir_data_valid, ir_data_ready;
    logic [IW-1:0]   ir_data;
    logic            inst_valid, inst_ready;
    logic [IW-1:0]   inst;
    logic [PCW-1:0]  inst_pc;
    logic            redirect_valid;
    logic [PCW-1:0]  redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            fetch_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH   (PCW),
        .INST_WIDTH (IW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Bus model: accepted requests return in order after bus_lat cycles.
    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t bus_q[$];
    int   bus_lat  = 1;
    bit   bus_hold = 1'b0;
    int   last_due = 0;
    bit   nop_mode = 1'b1;

    // Stream-level reference state.
    logic [31:0] exp_pc, exp_addr, stall_addr;
    bit          stall_prev, redir_prev;

    // Values sampled mid-cycle.
    bit          s_av, s_iv, s_mis;
    logic [31:0] s_addr, s_pc, s_inst;

    typedef struct {
        bit          do_rst;
        bit          ar;
        bit          ir;
        bit          e_av;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[15];

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return nop_mode ? NOP : (a ^ 32'hC3A5_0F69);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        ir_addr_ready  = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ir_data_valid  = 1'b0;
        ir_data        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset addr_valid", ir_addr_valid, 1'b0);
        chk("reset inst_valid", inst_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("reset misaligned", fetch_misaligned, 1'b0);
`endif
        bus_q.delete();
        last_due   = 0;
        exp_pc     = RST_PC;
        exp_addr   = RST_PC;
        stall_prev = 1'b0;
        redir_prev = 1'b0;
        rst        = 1'b1;
    endtask

    // Reference checks applied to every cycle at the sampling point.
    task automatic monitor();
        int due;
        if (stall_prev) begin
            chk("addr_valid held", s_av, 1'b1);
            chk("addr held", s_addr, stall_addr);
        end
        if (redir_prev) chk("inst_valid after redirect", s_iv, 1'b0);
        chk("credit limit", (bus_q.size() <= DEPTH) ? 1 : 0, 1);
        if (s_iv && inst_ready) begin
            $display("cycle %0d: decoder takes pc=%h inst=%h", cyc, s_pc, s_inst);
            chk("inst_pc", s_pc, exp_pc);
            chk("inst data", s_inst, data_fn(s_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (ir_data_valid && ir_data_ready && bus_q.size() > 0) void'(bus_q.pop_front());
        if (s_av && ir_addr_ready) begin
            chk("fetch addr", s_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            due = cyc + bus_lat;
            if (due < last_due) due = last_due;
            last_due = due;
            bus_q.push_back('{s_addr, due});
        end
        stall_prev = s_av && !ir_addr_ready && !redirect_valid;
        stall_addr = s_addr;
        redir_prev = redirect_valid;
        if (redirect_valid) begin
            exp_pc   = {redirect_pc[31:2], 2'b00};
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
    endtask

    // One clock cycle: drive bus response, sample, update model, advance.
    task automatic cycle();
        if (!bus_hold && bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            ir_data_valid = 1'b1;
            ir_data       = data_fn(bus_q[0].addr);
        end else begin
            ir_data_valid = 1'b0;
            ir_data       = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        s_av   = ir_addr_valid;
        s_addr = ir_addr;
        s_iv   = inst_valid;
        s_pc   = inst_pc;
        s_inst = inst;
`ifdef FETCH_ALIGN_CHECK_EN
        s_mis  = fetch_misaligned;
`else
        s_mis  = 1'b0;
`endif
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_inst(input string name, input logic [31:0] pc);
        int n;
        n = 0;
        inst_ready = 1'b1;
        do begin
            cycle();
            n++;
        end while (!s_iv && n < 20);
        chk(name, s_iv ? s_pc : 32'hBAD0_0000, pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Start-up from reset with a 1-cycle NOP bus: free-running decoder,
        // then a stalled decoder that fills the buffer before resuming.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};

        nop_mode = 1'b1;
        bus_lat  = 1;
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset();
            ir_addr_ready = vecs[i].ar;
            inst_ready    = vecs[i].ir;
            cycle();
            chk($sformatf("vec%0d addr_valid", i), s_av, vecs[i].e_av);
            chk($sformatf("vec%0d addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d inst_valid", i), s_iv, vecs[i].e_iv);
            if (vecs[i].e_iv) chk($sformatf("vec%0d inst_pc", i), s_pc, vecs[i].e_pc);
        end
        chk("data_ready out of reset", ir_data_ready, 1'b1);

        // Redirect with one entry buffered and one request outstanding.
        do_reset();
        ir_addr_ready = 1'b1;
        inst_ready    = 1'b0;
        repeat (3) cycle();
        bus_hold       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        chk("t3 buffered pc before redirect", s_iv ? s_pc : 32'hBAD0_0000, 32'h0);
        bus_hold   = 1'b0;
        inst_ready = 1'b1;
        cycle();
        chk("t3 addr after redirect", s_addr, 32'h100);
        wait_inst("t3 first pc after redirect", 32'h100);

        // Redirect coinciding with address handshake for 8 and response for 4.
        do_reset();
        ir_addr_ready = 1'b1;
        inst_ready    = 1'b1;
        bus_lat       = 1;
        repeat (2) cycle();
        bus_lat = 2;
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        chk("t4 setup addr", s_addr, 32'h8);
        chk("t4 setup addr_valid", s_av, 1'b1);
        chk("t4 setup data_valid", ir_data_valid, 1'b1);
        cycle();
        chk("t4 addr after redirect", s_addr, 32'h200);
        chk("t4 addr_valid after redirect", s_av, 1'b1);
        wait_inst("t4 first pc after redirect", 32'h200);

        // PC wrap-around at the top of the address space.
        bus_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_av && n < 10);
        chk("t5 top address issued", s_av ? s_addr : 32'hBAD0_0000, 32'hFFFF_FFFC);
        cycle();
        chk("t5 wrapped addr", s_addr, 32'h0);
        wait_inst("t5 first pc after redirect", 32'hFFFF_FFFC);

        // Randomized traffic with random stalls, latencies and redirects.
        nop_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            if (i == 600) do_reset();
            ir_addr_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            bus_lat        = $urandom_range(1, 4);
            bus_hold       = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
            redirect_pc    = $urandom;
`endif
            cycle();
        end
        bus_hold = 1'b0;

        // Misaligned redirect target.
        nop_mode = 1'b1;
        bus_lat  = 1;
        do_reset();
        ir_addr_ready = 1'b1;
        inst_ready    = 1'b1;
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cycle();
        cycle();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6 misaligned flag", s_mis, 1'b1);
        chk("t6 halted addr_valid", s_av, 1'b0);
        repeat (4) cycle();
        chk("t6 flag sticky", s_mis, 1'b1);
        chk("t6 still halted", s_av, 1'b0);
`else
        chk("t6 aligned addr", s_addr, 32'h100);
        wait_inst("t6 first pc after redirect", 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
